// File: rtl/path_stack_pkg.sv
// Shared direction and replay-state encodings for the path stack and the maze controller.
package path_stack_pkg;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_RIGHT = 2'd1,
    DIR_DOWN  = 2'd2,
    DIR_LEFT  = 2'd3
  } dirT;

  typedef enum logic [1:0] {
    RUN_IDLE   = 2'd0,
    RUN_EMIT   = 2'd1,
    RUN_WAIT   = 2'd2,
    RUN_FINISH = 2'd3
  } runStateT;

  // Address width that stays legal for a one-entry array.
  function automatic int addrWidth(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/path_stack_dir_ram.sv
// DEPTH x 2-bit direction store: one synchronous write port, two asynchronous read ports.
module dir_ram
  import path_stack_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int AW    = addrWidth(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] wAddr,
  input  logic [1:0]    wData,
  input  logic [AW-1:0] topAddr,
  output logic [1:0]    topData,
  input  logic [AW-1:0] runAddr,
  output logic [1:0]    runData
);

  logic [1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[wAddr] <= wData;
  end

  assign topData = mem[topAddr];
  assign runData = mem[runAddr];

endmodule

// File: rtl/path_stack.sv
// Direction stack for the maze solver with a paced bottom-to-top replay of the stored path.
//
// state      | meaning
// RUN_IDLE   | stack accepts push/pop, waits for run
// RUN_EMIT   | one-cycle runValid with runDir = entry[idx]
// RUN_WAIT   | PACE-1 idle cycles between moves
// RUN_FINISH | one-cycle runDone, then back to idle
module path_stack
  import path_stack_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int PACE  = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  logic [1:0] dirIn,
  output logic [1:0] dirTop,
  output logic       empStck,
  output logic       full,
  output logic       ovf,
  input  logic       run,
  output logic       busy,
  output logic       runValid,
  output logic [1:0] runDir,
  output logic       runDone
);

  localparam int AW = addrWidth(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [3:0] PACE_LOAD = (PACE >= 2) ? 4'(PACE - 2) : 4'd0;

  runStateT        state;
  logic [CW-1:0]   count;
  logic [CW-1:0]   idx;
  logic [CW-1:0]   runLast;
  logic [3:0]      paceCnt;

  logic            we;
  logic [AW-1:0]   wAddr;
  logic [1:0]      topData;
  logic [1:0]      runData;
  logic            stackEn;
  logic [CW-1:0]   countNext;
  logic            dropPush;

  assign stackEn = (state == RUN_IDLE);
  assign empStck = (count == '0);
  assign full    = (count == CW'(DEPTH));

  // Simultaneous push+pop on a non-empty stack replaces the top in place.
  always_comb begin
    we        = 1'b0;
    wAddr     = AW'(count);
    countNext = count;
    dropPush  = 1'b0;
    if (stackEn) begin
      if (push && pop && !empStck) begin
        we    = 1'b1;
        wAddr = AW'(count - CW'(1));
      end else if (push) begin
        if (!full) begin
          we        = 1'b1;
          countNext = count + CW'(1);
        end else begin
          dropPush = 1'b1;
        end
      end else if (pop && !empStck) begin
        countNext = count - CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      ovf   <= 1'b0;
    end else begin
      count <= countNext;
      if (dropPush) ovf <= 1'b1;
    end
  end

  dir_ram #(.DEPTH(DEPTH), .AW(AW)) uDirRam (
    .clk     (clk),
    .we      (we),
    .wAddr   (wAddr),
    .wData   (dirIn),
    .topAddr (AW'(count - CW'(1))),
    .topData (topData),
    .runAddr (AW'(idx)),
    .runData (runData)
  );

  assign dirTop = empStck ? 2'd0 : topData;
  assign runDir = runValid ? runData : 2'd0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= RUN_IDLE;
      idx      <= '0;
      runLast  <= '0;
      paceCnt  <= '0;
      busy     <= 1'b0;
      runValid <= 1'b0;
      runDone  <= 1'b0;
    end else begin
      case (state)
        RUN_IDLE: begin
          if (run) begin
            if (!empStck) begin
              idx      <= '0;
              runLast  <= count - CW'(1);
              busy     <= 1'b1;
              runValid <= 1'b1;
              state    <= RUN_EMIT;
            end else begin
              runDone <= 1'b1;
              state   <= RUN_FINISH;
            end
          end
        end
        RUN_EMIT: begin
          runValid <= 1'b0;
          if (idx == runLast) begin
            busy    <= 1'b0;
            runDone <= 1'b1;
            state   <= RUN_FINISH;
          end else begin
            idx <= idx + CW'(1);
            if (PACE == 1) begin
              runValid <= 1'b1;
              state    <= RUN_EMIT;
            end else begin
              paceCnt <= PACE_LOAD;
              state   <= RUN_WAIT;
            end
          end
        end
        RUN_WAIT: begin
          if (paceCnt == 4'd0) begin
            runValid <= 1'b1;
            state    <= RUN_EMIT;
          end else begin
            paceCnt <= paceCnt - 4'd1;
          end
        end
        RUN_FINISH: begin
          runDone <= 1'b0;
          state   <= RUN_IDLE;
        end
        default: state <= RUN_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_path_stack.sv
// Directed bench for path_stack: stack ops, overflow on a 4-deep copy, paced replay, reset abort.
module tb_path_stack;
  import path_stack_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       push = 1'b0;
  logic       pop = 1'b0;
  logic       run = 1'b0;
  logic [1:0] dirIn = 2'd0;

  logic [1:0] dirTop, runDir, dirTopS, runDirS;
  logic       empStck, full, ovf, busy, runValid, runDone;
  logic       empStckS, fullS, ovfS, busyS, runValidS, runDoneS;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  path_stack #(.DEPTH(256), .PACE(4)) dut (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .dirIn(dirIn),
    .dirTop(dirTop), .empStck(empStck), .full(full), .ovf(ovf),
    .run(run), .busy(busy), .runValid(runValid), .runDir(runDir), .runDone(runDone)
  );

  path_stack #(.DEPTH(4), .PACE(4)) dutS (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .dirIn(dirIn),
    .dirTop(dirTopS), .empStck(empStckS), .full(fullS), .ovf(ovfS),
    .run(run), .busy(busyS), .runValid(runValidS), .runDir(runDirS), .runDone(runDoneS)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic doOp(input logic p, input logic q, input logic [1:0] d);
    push = p; pop = q; dirIn = d;
    tick();
    push = 1'b0; pop = 1'b0;
  endtask

  task automatic doRun();
    run = 1'b1;
    tick();
    run = 1'b0;
  endtask

  logic [1:0] seq [4];
  int seen;

  initial begin
    seq[0] = 2'd1; seq[1] = 2'd1; seq[2] = 2'd2; seq[3] = 2'd3;

    // reset values
    #2;
    chk("rstEmp", empStck, 1'b1);
    chk("rstFull", full, 1'b0);
    chk("rstTop", dirTop, 2'd0);
    chk("rstBusy", busy, 1'b0);
    chk("rstValid", runValid, 1'b0);
    chk("rstDir", runDir, 2'd0);
    chk("rstDone", runDone, 1'b0);
    chk("rstOvf", ovf, 1'b0);
    tick();
    rst = 1'b0;

    // push 1,2,3 then pop down past empty
    doOp(1, 0, 2'd1);
    doOp(1, 0, 2'd2);
    doOp(1, 0, 2'd3);
    chk("push3Top", dirTop, 2'd3);
    chk("push3Emp", empStck, 1'b0);
    doOp(0, 1, 2'd0);
    doOp(0, 1, 2'd0);
    chk("pop2Top", dirTop, 2'd1);
    doOp(0, 1, 2'd0);
    chk("pop3Emp", empStck, 1'b1);
    chk("pop3Top", dirTop, 2'd0);
    doOp(0, 1, 2'd0);
    chk("pop4Emp", empStck, 1'b1);
    doOp(1, 0, 2'd2);
    chk("afterIgnTop", dirTop, 2'd2);
    doOp(0, 1, 2'd0);
    chk("afterIgnEmp", empStck, 1'b1);

    // overflow on the 4-deep copy
    doReset();
    doOp(1, 0, 2'd0);
    doOp(1, 0, 2'd1);
    doOp(1, 0, 2'd2);
    chk("s3Full", fullS, 1'b0);
    doOp(1, 0, 2'd3);
    chk("s4Full", fullS, 1'b1);
    chk("s4Ovf", ovfS, 1'b0);
    doOp(1, 0, 2'd1);
    chk("s5Ovf", ovfS, 1'b1);
    chk("s5Full", fullS, 1'b1);
    chk("s5Top", dirTopS, 2'd3);
    doOp(0, 1, 2'd0);
    chk("ovfSticky", ovfS, 1'b1);
    chk("ovfPopTop", dirTopS, 2'd2);

    // push+pop replaces the top; on empty it is a plain push
    doReset();
    chk("ovfCleared", ovfS, 1'b0);
    doOp(1, 0, 2'd0);
    doOp(1, 0, 2'd1);
    doOp(1, 1, 2'd2);
    chk("ppTop", dirTop, 2'd2);
    doOp(0, 1, 2'd0);
    chk("ppPopTop", dirTop, 2'd0);
    chk("ppPopEmp", empStck, 1'b0);
    doOp(0, 1, 2'd0);
    chk("ppCount2Emp", empStck, 1'b1);
    doOp(1, 1, 2'd3);
    chk("ppEmptyTop", dirTop, 2'd3);
    chk("ppEmptyEmp", empStck, 1'b0);

    // paced replay of 1,1,2,3; push and a second run during replay are ignored
    doReset();
    for (int i = 0; i < 4; i++) doOp(1, 0, seq[i]);
    doRun();
    for (int c = 0; c <= 20; c++) begin
      chk($sformatf("rpValid%0d", c), runValid, (c % 4 == 0) && (c <= 12));
      if ((c % 4 == 0) && (c <= 12))
        chk($sformatf("rpDir%0d", c), runDir, seq[c / 4]);
      chk($sformatf("rpDone%0d", c), runDone, c == 13);
      chk($sformatf("rpBusy%0d", c), busy, c <= 12);
      push = (c == 1);
      dirIn = 2'd0;
      run = (c == 5);
      tick();
    end
    push = 1'b0; run = 1'b0;
    chk("rpKeepTop", dirTop, 2'd3);
    chk("rpKeepFull", fullS, 1'b1);
    doOp(0, 1, 2'd0);
    doOp(0, 1, 2'd0);
    doOp(0, 1, 2'd0);
    chk("rpKeepPop3", dirTop, 2'd1);
    doOp(0, 1, 2'd0);
    chk("rpKeepPop4", empStck, 1'b1);

    // replay of an empty stack
    doRun();
    chk("emDone0", runDone, 1'b1);
    chk("emBusy0", busy, 1'b0);
    chk("emValid0", runValid, 1'b0);
    tick();
    chk("emDone1", runDone, 1'b0);
    chk("emBusy1", busy, 1'b0);
    chk("emValid1", runValid, 1'b0);

    // reset after the second move aborts the replay
    for (int i = 0; i < 4; i++) doOp(1, 0, seq[i]);
    doRun();
    chk("abValid0", runValid, 1'b1);
    repeat (4) tick();
    chk("abValid1", runValid, 1'b1);
    chk("abDir1", runDir, 2'd1);
    rst = 1'b1;
    #1;
    chk("abBusy", busy, 1'b0);
    chk("abEmp", empStck, 1'b1);
    chk("abValidNow", runValid, 1'b0);
    tick();
    rst = 1'b0;
    seen = 0;
    for (int c = 0; c < 16; c++) begin
      if (runValid || runDone || busy) seen++;
      tick();
    end
    chk("abQuiet", seen, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/path_stack.md
PATH_STACK -- requirements
Module: path_stack

Interface
REQ-001 Parameter DEPTH, default 256, is the maximum number of stored direction entries (one per maze cell).
REQ-002 Parameter PACE, default 4, is the number of clock cycles between consecutive replayed moves; legal range is 1..15.
REQ-003 clk  input  1  is the single clock; all state changes on its rising edge.
REQ-004 rst  input  1  is the reset: asynchronous, active-high.
REQ-005 push  input  1  is a one-cycle request to store dirIn on top of the stack.
REQ-006 pop  input  1  is a one-cycle request to remove the top entry.
REQ-007 dirIn  input  2  is the direction to push: 0=up, 1=right, 2=down, 3=left.
REQ-008 dirTop  output  2  is the direction of the current top entry; it is 0 when the stack is empty.
REQ-009 empStck  output  1  is high when the entry count is 0.
REQ-010 full  output  1  is high when the entry count equals DEPTH.
REQ-011 ovf  output  1  is a sticky flag: a push was dropped because the stack was full.
REQ-012 run  input  1  is a one-cycle request to replay the stored path from the bottom of the stack to the top.
REQ-013 busy  output  1  is high while a replay is in progress.
REQ-014 runValid  output  1  is a one-cycle strobe qualifying runDir.
REQ-015 runDir  output  2  is the replayed direction; it is valid only while runValid is high.
REQ-016 runDone  output  1  is a one-cycle pulse marking the end of a replay.

Function
REQ-017 The stack shall hold a count register, width clog2(DEPTH)+1, and DEPTH 2-bit entries; entry 0 is the bottom.
REQ-018 A push alone with count<DEPTH shall write dirIn to entry[count] and increment count at the next edge.
REQ-019 A pop alone with count>0 shall decrement count at the next edge; entry contents are left unchanged.
REQ-020 Push and pop together with count>0 shall overwrite entry[count-1] with dirIn and leave count unchanged.
REQ-021 Push and pop together with count=0 shall behave as a push alone.
REQ-022 A push with full=1 (and no pop) shall be dropped and shall set ovf; ovf clears only on reset.
REQ-023 A pop with empStck=1 shall be ignored, with no state change.
REQ-024 empStck, full and dirTop shall be combinational from the count and entry registers; they update in the cycle after the edge that changes them.
REQ-025 The replay FSM shall have the states IDLE, EMIT, WAIT and FINISH.
REQ-026 In IDLE, run=1 with count>0 shall clear the index register to 0 and go to EMIT; busy=1 from the next cycle.
REQ-027 In IDLE, run=1 with count=0 shall go to FINISH directly; no runValid is produced.
REQ-028 In EMIT, the block shall assert runValid=1 with runDir=entry[index] for exactly one cycle.
REQ-029 From EMIT, the FSM shall go to FINISH if index=count-1; otherwise it shall increment index and go to WAIT (or directly back to EMIT when PACE=1).
REQ-030 WAIT shall last PACE-1 cycles, counted by a 4-bit pace counter, and then return to EMIT; consecutive runValid rising edges are therefore exactly PACE cycles apart.
REQ-031 In FINISH, the block shall assert runDone=1 for one cycle, set busy=0 and return to IDLE.
REQ-032 While busy=1 or in FINISH, push, pop and run shall be ignored; stack contents and count are preserved across a replay.
REQ-033 run asserted while not in IDLE shall be ignored and shall not be queued.
REQ-034 Replay length shall use the count captured at the IDLE-to-EMIT transition.

Reset
REQ-035 rst=1 shall, asynchronously, set count=0, ovf=0, index=0, pace counter=0 and FSM state=IDLE.
REQ-036 While in or leaving reset, outputs shall read empStck=1, full=0, dirTop=0, busy=0, runValid=0, runDir=0 and runDone=0.
REQ-037 Reset during a replay shall abort it with no runDone pulse; entry contents need not be cleared.

Structure
REQ-038 The direction encodings (UP=0, RIGHT=1, DOWN=2, LEFT=3) and the replay state encodings shall live in a shared package/include so that the maze controller uses the same values.
REQ-039 The entry array shall be a sub-module dir_ram: DEPTH x 2 bits, one synchronous write port, one asynchronous read address used for dirTop, and one asynchronous read address used for runDir.

Verification
REQ-040 Reset, then push 1,2,3 on consecutive cycles -> count=3, dirTop=3, empStck=0; then pop twice -> dirTop=1; then pop twice -> empStck=1, and the 4th pop is ignored.
REQ-041 With DEPTH=4, push 5 times -> full=1 after the 4th push, the 5th push sets ovf=1, and dirTop equals the 4th value.
REQ-042 Push 0,1 then push+pop with dirIn=2 together -> count=2, dirTop=2.
REQ-043 Push 1,1,2,3 with PACE=4 and pulse run -> runValid pulses 4 cycles apart with runDir=1,1,2,3 in that order; runDone follows one cycle after the last runValid; count is still 4.
REQ-044 Pulse run with the stack empty -> runDone one cycle later, no runValid, busy stays 0.
REQ-045 Assert rst after the 2nd runValid of a 4-entry replay -> busy=0 and empStck=1 immediately, and no further runValid or runDone occurs.
